// File: rtl/serial_subtractor_8bit.sv
// rtl/serial_subtractor_8bit.sv - bit-serial x - y - bin subtractor with start/busy/done handshake
//
// One full-subtractor cell is reused LSB->MSB, one bit per clock, with the
// borrow held in a register between bits. The result is held until the next
// accepted start.
//
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf. Without it there is no ovf port and no extra register.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2), default 8
//
// Ports:
//   clk    in   1      clock, all state updates on rising edge
//   rst    in   1      synchronous active-high reset, dominates all inputs
//   start  in   1      request, sampled only in IDLE or DONE
//   x      in   WIDTH  minuend
//   y      in   WIDTH  subtrahend
//   bin    in   1      borrow-in
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse, diff/bout valid
//   diff   out  WIDTH  x - y - bin mod 2^WIDTH
//   bout   out  1      final borrow
//   ovf    out  1      signed overflow (SERIAL_SUB_OVF_EN only)

module serial_subtractor_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             borrow;
    logic [CW-1:0]    cnt;

    // Full-subtractor cell on the current LSBs of the shifting operands.
    logic bit_a;
    logic bit_b;
    logic bit_d;
    logic borrow_next;

    always_comb begin
        bit_a       = a_reg[0];
        bit_b       = b_reg[0];
        bit_d       = bit_a ^ bit_b ^ borrow;
        borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Operands are captured here so x/y/bin may change freely afterwards.
                        a_reg  <= x;
                        b_reg  <= y;
                        borrow <= bin;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end

                SHIFT: begin
                    // New bit enters at the MSB; after WIDTH shifts the LSB lands at diff[0].
                    diff   <= {bit_d, diff[WIDTH-1:1]};
                    a_reg  <= a_reg >> 1;
                    b_reg  <= b_reg >> 1;
                    borrow <= borrow_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        bout  <= borrow_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit a_reg[0]/b_reg[0] are the latched operand MSBs
                        // and bit_d is the result MSB, so no separate MSB registers are needed.
                        ovf   <= (bit_a != bit_b) && (bit_d != bit_a);
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// tb/tb_serial_subtractor_8bit.sv - scoreboard bench for serial_subtractor_8bit

module tb_serial_subtractor_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       bout;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    serial_subtractor_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ovf, bout, diff} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] xv, input logic [7:0] yv, input logic bv);
        logic [8:0] r;
        logic       o;
        r = {1'b0, xv} - {1'b0, yv} - {8'd0, bv};
        o = (xv[7] != yv[7]) && (r[7] != xv[7]);
        return {o, r};
    endfunction

    function automatic logic [9:0] observed();
        logic [9:0] v;
        v = {1'b0, bout, diff};
`ifdef SERIAL_SUB_OVF_EN
        v[9] = ovf;
`endif
        return v;
    endfunction

    function automatic logic [9:0] mask(input logic [9:0] v);
`ifdef SERIAL_SUB_OVF_EN
        return v;
`else
        return {1'b0, v[8:0]};
`endif
    endfunction

    task automatic pop_check(input string tag);
        logic [9:0] e;
        check_eq({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq(tag, 32'(observed()), 32'(mask(e)));
        end
    endtask

    // One op from IDLE; optionally re-pulses start at cycles 3-5 while busy.
    task automatic do_op(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                         input logic bv, input bit repulse);
        int cyc;
        bit got;
        @(negedge clk);
        x = xv; y = yv; bin = bv; start = 1'b1;
        sb_q.push_back(model(xv, yv, bv));
        cyc = 0;
        got = 1'b0;
        while (cyc < 30 && !got) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                x = 8'($urandom); y = 8'($urandom); bin = 1'($urandom);
            end
            start = (repulse && cyc >= 3 && cyc <= 5);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, 32'(cyc), 32'd9);
        if (got) pop_check(tag);
        @(negedge clk);
        check_eq({tag, "_done_single"}, 32'(done), 32'd0);
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int ndone;
        int last_done;
        rst = 1'b1; start = 1'b0; x = '0; y = '0; bin = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_diff", 32'(diff), 32'd0);
        check_eq("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check_eq("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;

        do_op("d7_b5_b0", 8'hD7, 8'hB5, 1'b0, 1'b0);
        check_eq("d7_b5_b0_diff", 32'(diff), 32'h22);
        do_op("d7_b5_b1", 8'hD7, 8'hB5, 1'b1, 1'b0);
        check_eq("d7_b5_b1_diff", 32'(diff), 32'h21);
        do_op("05_07", 8'h05, 8'h07, 1'b0, 1'b0);
        check_eq("05_07_bout", 32'(bout), 32'd1);
        do_op("00_00_b1", 8'h00, 8'h00, 1'b1, 1'b0);
        check_eq("00_00_b1_diff", 32'(diff), 32'hFF);
        do_op("80_01", 8'h80, 8'h01, 1'b0, 1'b0);
        do_op("7f_ff", 8'h7F, 8'hFF, 1'b0, 1'b0);
        do_op("07_05", 8'h07, 8'h05, 1'b0, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        do_op("80_01_ovf", 8'h80, 8'h01, 1'b0, 1'b0);
        check_eq("80_01_ovf_bit", 32'(ovf), 32'd1);
`endif
        do_op("repulse", 8'h3C, 8'h5A, 1'b1, 1'b1);

        // Abort on the 4th SHIFT cycle.
        @(negedge clk);
        x = 8'h99; y = 8'h11; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_diff", 32'(diff), 32'd0);
        check_eq("abort_bout", 32'(bout), 32'd0);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_eq("abort_no_done", 32'(ndone), 32'd0);
        do_op("after_abort", 8'h12, 8'h34, 1'b1, 1'b0);

        // Back-to-back random ops with start held high.
        @(negedge clk);
        x = 8'($urandom); y = 8'($urandom); bin = 1'($urandom); start = 1'b1;
        sb_q.push_back(model(x, y, bin));
        ndone = 0;
        cyc = 0;
        last_done = 0;
        while (ndone < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
                pop_check("b2b");
                if (ndone > 1) check_eq("b2b_period", 32'(cyc - last_done), 32'd9);
                last_done = cyc;
                if (ndone < 1000) begin
                    x = 8'($urandom); y = 8'($urandom); bin = 1'($urandom);
                    sb_q.push_back(model(x, y, bin));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check_eq("b2b_count", 32'(ndone), 32'd1000);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
